aes_block_uart_tx: RTL and testbench
====================================

Name: aes_block_uart_tx

Overview:
- Transmit-side counterpart of the 16-byte UART block receiver in the AES FPGA test top.
- Accepts one 128-bit AES result block (ciphertext or plaintext) through a valid/ready handshake.
- Serializes the block as 16 UART 8N1 frames on `tx`, sending bytes back-to-back and LSB first.
- Pulses `done` once the last stop bit has finished.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUDRATE, 115_200, UART bit rate.
- BIT_PERIOD_CLKS, CLK_FREQ/BAUDRATE (434), clocks per UART bit. Must be >= 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_block  input  128  block to send. Byte 0 = in_block[127:120] and is sent first; byte 15 = in_block[7:0] and is sent last.
- in_valid  input  1  in_block is valid.
- in_ready  output  1  block is ready to accept a new block; high only in IDLE.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse at the end of the block.

Behaviour:
- Reset values (asynchronous on reset=0): tx=1, in_ready=1, busy=0, done=0. FSM=IDLE; all counters and the shift register are 0.
- Accept occurs on the rising edge where in_valid && in_ready. At that edge, in_block is latched into a 128-bit shift register, byte_cnt=0, and the FSM moves to START.
- in_block and in_valid are ignored while busy.
- FSM states:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx = current byte[bit_cnt], bit_cnt 0..7, LSB first.
  - STOP: tx=1.
- Every state except IDLE holds for exactly BIT_PERIOD_CLKS cycles, counted by baud_cnt from 0 to BIT_PERIOD_CLKS-1. baud_cnt width is $clog2(BIT_PERIOD_CLKS).
- Transitions:
  - START to DATA at the end of its bit period.
  - DATA: bit_cnt increments at the end of each bit period; after bit 7, go to STOP.
  - STOP, byte_cnt<15: shift the register left 8 bits, increment byte_cnt, go to START. There is no inter-byte idle gap.
  - STOP, byte_cnt==15: go to IDLE.
- tx is registered. The start bit appears in the cycle after acceptance. A full block occupies 16×10×BIT_PERIOD_CLKS = 69440 cycles.
- done is registered and high for exactly one cycle: the first cycle back in IDLE, where in_ready is also 1. A new block may be accepted in that same cycle, giving back-to-back blocks with one idle-high cycle between them.
- Reset asserted mid-block: tx returns to 1 immediately, the partial frame is abandoned, and done is not pulsed. The block is not resumed after reset deasserts.
- in_valid dropping before acceptance is legal; nothing is sent.

Optional Feature:
- Macro: AES_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. tx = XOR of the 8 data bits (even parity) for BIT_PERIOD_CLKS cycles. Frame is 11 bits; a block takes 16×11×BIT_PERIOD_CLKS = 76384 cycles.
- When undefined: 8N1 frames only, and no parity logic or state encoding is generated.

Decomposition:
- Package aes_uart_pkg holds:
  - CLK_FREQ_DEF, BAUDRATE_DEF, BLOCK_BYTES=16;
  - the tx state enum {IDLE, START, DATA, PARITY, STOP};
  - a function computing BIT_PERIOD_CLKS.
- Natural sub-module: uart_tx_byte, a single-byte 8N1 (optional parity) serializer with byte_valid/byte_ready/byte_done.
- aes_block_uart_tx is then the 16-byte sequencer plus shift register around it. Timing stays gap-free: the next byte's start bit follows the previous stop bit directly.

Test Plan:
- Timing check: after reset release, drive in_block = 0x00FF0000_7A9B9B9B_86D2D27A_7A7B7A86 with in_valid=1 for one cycle, accepted at edge T.
  - tx falls at T+1.
  - Decoding frames yields bytes 00, FF, 00, 00, 7A, … 86 in order.
  - Every bit lasts 434 cycles.
  - done is high only in cycle T+69441.
- Loopback: feed tx into the existing UART receiver of the test top and confirm it reassembles the same 128-bit block.
- in_valid held high across two different blocks: the second block is accepted in the done cycle. Exactly one tx=1 cycle separates the last stop bit of block 1 from the first start bit of block 2.
- in_valid pulsed mid-transmission with a different block: that block is ignored and the output stream still equals the first block.
- Reset driven low during byte 5, bit 3: tx=1, busy=0, in_ready=1 immediately, and done never pulses. A fresh block sent afterwards transmits correctly from byte 0.
- With AES_TX_PARITY_EN: byte 0x7A (five ones) gives parity bit 1 and byte 0xFF gives 0. Block duration is 76384 cycles.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared constants, tx state encoding and baud helper for the AES UART block transmitter.
// Optional feature macro: AES_TX_PARITY_EN adds an even-parity bit to every frame.
package aes_uart_pkg;

  localparam int unsigned CLK_FREQ_DEF = 50_000_000;
  localparam int unsigned BAUDRATE_DEF = 115_200;
  localparam int unsigned BLOCK_BYTES  = 16;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned BLOCK_W      = BLOCK_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef AES_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

  // Clocks per UART bit for a given system clock and bit rate.
  function automatic int unsigned bit_period_clks(input int unsigned clk_freq,
                                                  input int unsigned baudrate);
    return clk_freq / baudrate;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serializer: start, 8 data bits LSB first, optional even parity, stop.
// Optional feature macro: AES_TX_PARITY_EN inserts the PARITY bit.
// byte_ready_o is high in IDLE and in the last cycle of STOP, so a byte offered
// there starts the next frame with no idle gap.
module uart_tx_byte
  import aes_uart_pkg::*;
#(
  parameter int unsigned BIT_PERIOD_CLKS = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              byte_done_o,
  output logic              tx_o
);

  localparam int unsigned       BAUD_W    = (BIT_PERIOD_CLKS > 1) ? $clog2(BIT_PERIOD_CLKS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_PERIOD_CLKS - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              bit_end_c;

  assign bit_end_c    = (baud_q == BAUD_LAST);
  assign byte_ready_o = ready_q;
  assign byte_done_o  = done_q;
  assign tx_o         = tx_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Next-state, bit timing, and line level derived from the next state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    if (state_q != IDLE) begin
      baud_d = bit_end_c ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (byte_valid_i) begin
          state_d = START;
          baud_d  = '0;
          data_d  = byte_i;
        end
      end
      START: begin
        if (bit_end_c) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef AES_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef AES_TX_PARITY_EN
      PARITY: begin
        if (bit_end_c) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end_c) begin
          done_d = 1'b1;
          if (byte_valid_i) begin
            state_d = START;
            data_d  = byte_i;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
`ifdef AES_TX_PARITY_EN
      PARITY:  tx_d = ^data_d;
`endif
      default: tx_d = 1'b1;
    endcase

    ready_d = (state_d == IDLE) || ((state_d == STOP) && (baud_d == BAUD_LAST));
  end

endmodule

// File: rtl/aes_block_uart_tx.sv
// 16-byte AES block UART transmitter: latches a block, streams it MSB byte first
// through uart_tx_byte with no inter-byte gap, and pulses done after the last stop bit.
// Optional feature macro: AES_TX_PARITY_EN (even parity per frame, handled in uart_tx_byte).
module aes_block_uart_tx
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = CLK_FREQ_DEF,
  parameter int unsigned BAUDRATE        = BAUDRATE_DEF,
  parameter int unsigned BIT_PERIOD_CLKS = bit_period_clks(CLK_FREQ, BAUDRATE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam int unsigned      CNT_W     = $clog2(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);

  logic [BLOCK_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               done_q, done_d;

  logic [BYTE_W-1:0]  byte_c;
  logic               byte_valid_c;
  logic               byte_ready;
  logic               byte_done;

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  uart_tx_byte #(
    .BIT_PERIOD_CLKS(BIT_PERIOD_CLKS)
  ) u_byte (
    .clk         (clk),
    .reset       (reset),
    .byte_i      (byte_c),
    .byte_valid_i(byte_valid_c),
    .byte_ready_o(byte_ready),
    .byte_done_o (byte_done),
    .tx_o        (tx)
  );

  // Block shift register, byte counter and handshake flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q     <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  // Sequencer: byte 0 comes straight from in_block on accept; later bytes are offered
  // from sreg_q[119:112] at each stop-bit end, and the register shifts once that byte is taken.
  always_comb begin
    sreg_d       = sreg_q;
    byte_cnt_d   = byte_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    byte_c       = sreg_q[BLOCK_W-BYTE_W-1 -: BYTE_W];
    byte_valid_c = 1'b0;

    if (!busy_q) begin
      byte_c       = in_block[BLOCK_W-1 -: BYTE_W];
      byte_valid_c = in_valid;
      if (in_valid && byte_ready) begin
        busy_d     = 1'b1;
        sreg_d     = in_block;
        byte_cnt_d = '0;
      end
    end else begin
      byte_valid_c = (byte_cnt_q != LAST_BYTE);
      if (byte_ready && (byte_cnt_q == LAST_BYTE)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      if (byte_done) begin
        sreg_d     = sreg_q << BYTE_W;
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
    end

    in_ready_d = !busy_d;
  end

endmodule

// File: tb/tb_aes_block_uart_tx.sv
// Self-checking bench for aes_block_uart_tx, run at 5 clocks per bit.
module tb_aes_block_uart_tx;
  import aes_uart_pkg::*;

  localparam int P = 5;
`ifdef AES_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int N = 16 * FRAME * P;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] in_block = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, tx, busy, done;

  int checks = 0;
  int failures = 0;
  logic [FRAME-1:0] fr [16];

  typedef struct {
    string        name;
    logic [127:0] blk;
    logic [7:0]   exp_b0;
    logic [7:0]   exp_b15;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  aes_block_uart_tx #(.CLK_FREQ(500), .BAUDRATE(100)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_block(in_block),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference line level in cycle T+k for a block accepted at edge T.
  function automatic logic model_tx(input logic [127:0] blk, input int k);
    int idx, bn, pos;
    logic [7:0] b;
    idx = (k - 1) / P;
    bn  = idx / FRAME;
    pos = idx % FRAME;
    b   = blk[127 - 8*bn -: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef AES_TX_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic start_block(input string nm, input logic [127:0] blk);
    @(negedge clk);
    chk({nm, " idle before accept"}, 128'({in_ready, tx, busy}), 128'(3'b110));
    in_block = blk;
    in_valid = 1'b1;
  endtask

  // Follows one block from the cycle after acceptance through its done cycle.
  task automatic check_stream(input string nm, input logic [127:0] blk,
                              input bit keep_valid, input logic [127:0] next_blk,
                              input bit inject, input logic [127:0] inj_blk);
    int errs = 0;
    int serrs = 0;
    int ferrs = 0;
    logic [127:0] dec;
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({nm, " tx falls at T+1"}, 128'(tx), 128'(1'b0));
        if (keep_valid) in_block = next_blk;
        else in_valid = 1'b0;
      end
      if (inject && k == N/2) begin
        in_valid = 1'b1;
        in_block = inj_blk;
      end
      if (inject && k == N/2 + 1) in_valid = 1'b0;
      if (tx !== model_tx(blk, k)) errs++;
      if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) serrs++;
      if ((k - 1) % P == P / 2) fr[((k-1)/P)/FRAME][((k-1)/P)%FRAME] = tx;
    end
    chk({nm, " waveform cycle errors"}, 128'(errs), 128'(0));
    chk({nm, " status errors during block"}, 128'(serrs), 128'(0));
    @(negedge clk);
    chk({nm, " done cycle done/tx/busy/in_ready"}, 128'({done, tx, busy, in_ready}), 128'(4'b1101));
    for (int b = 0; b < 16; b++) begin
      dec[127 - 8*b -: 8] = fr[b][8:1];
      if (fr[b][0] !== 1'b0 || fr[b][FRAME-1] !== 1'b1) ferrs++;
    end
    chk({nm, " framing errors"}, 128'(ferrs), 128'(0));
    chk({nm, " decoded block"}, dec, blk);
  endtask

  initial begin
    int errs;
    vecs[0] = '{"timing", 128'h00FF0000_7A9B9B9B_86D2D27A_7A7B7A86, 8'h00, 8'h86};
    vecs[1] = '{"ones",   128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 8'hFF, 8'hFF};
    vecs[2] = '{"alt",    128'h55AA55AA_AA55AA55_0F0F0F0F_F0F0F0F0, 8'h55, 8'hF0};
    vecs[3] = '{"count",  128'h01234567_89ABCDEF_FEDCBA98_76543210, 8'h01, 8'h10};
    vecs[4] = '{"zeros",  128'h00000000_00000000_00000000_00000000, 8'h00, 8'h00};

    chk("default bit period", 128'(bit_period_clks(CLK_FREQ_DEF, BAUDRATE_DEF)), 128'(434));

    // Reset values while held in reset.
    @(negedge clk);
    chk("reset tx/in_ready/busy/done", 128'({tx, in_ready, busy, done}), 128'(4'b1100));
    @(negedge clk);
    reset = 1'b1;

    // Idle line with no valid: nothing sent.
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) errs++;
    end
    chk("idle quiet", 128'(errs), 128'(0));

    // Table of single blocks.
    for (int v = 0; v < 5; v++) begin
      start_block(vecs[v].name, vecs[v].blk);
      check_stream(vecs[v].name, vecs[v].blk, 1'b0, '0, 1'b0, '0);
      chk({vecs[v].name, " first byte"}, 128'(fr[0][8:1]), 128'(vecs[v].exp_b0));
      chk({vecs[v].name, " last byte"}, 128'(fr[15][8:1]), 128'(vecs[v].exp_b15));
`ifdef AES_TX_PARITY_EN
      if (v == 0) begin
        chk("parity of FF", 128'(fr[1][9]), 128'(1'b0));
        chk("parity of 7A", 128'(fr[4][9]), 128'(1'b1));
      end
`endif
    end

    // Back-to-back: second block accepted in the done cycle.
    start_block("b2b1", vecs[2].blk);
    check_stream("b2b1", vecs[2].blk, 1'b1, vecs[3].blk, 1'b0, '0);
    check_stream("b2b2", vecs[3].blk, 1'b0, '0, 1'b0, '0);

    // A different block pulsed mid-transmission is ignored.
    start_block("inject", vecs[0].blk);
    check_stream("inject", vecs[0].blk, 1'b0, '0, 1'b1, vecs[1].blk);

    // Reset during byte 5, bit 3.
    start_block("abort", vecs[3].blk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat ((5*FRAME + 4) * P + 1) @(negedge clk);
    chk("abort mid-frame busy", 128'(busy), 128'(1'b1));
    reset = 1'b0;
    #1;
    chk("abort immediate tx/busy/in_ready/done", 128'({tx, busy, in_ready, done}), 128'(4'b1010));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    errs = 0;
    for (int i = 0; i < 3 * FRAME * P; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0) errs++;
    end
    chk("abort no resume no done", 128'(errs), 128'(0));
    start_block("after abort", vecs[0].blk);
    check_stream("after abort", vecs[0].blk, 1'b0, '0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
